// File: rtl/rxmac_to_ll8_buf.sv
// RX MAC byte stream to LocalLink-8 bridge with a frame-tagged FIFO.
// Errors and overruns close the frame with an error-tagged eof entry; per-frame counters are kept.
module rxmac_to_ll8_buf #(
  parameter int AWIDTH    = 4,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 clear,
  input  logic [7:0]           rx_data,
  input  logic                 rx_valid,
  input  logic                 rx_error,
  input  logic                 rx_ack,
  output logic [7:0]           ll_data,
  output logic                 ll_sof,
  output logic                 ll_eof,
  output logic                 ll_error,
  output logic                 ll_src_rdy,
  input  logic                 ll_dst_rdy,
  output logic [CNT_WIDTH-1:0] frames_ok,
  output logic [CNT_WIDTH-1:0] frames_err,
  output logic [CNT_WIDTH-1:0] overruns,
  output logic [AWIDTH:0]      fifo_level
);

  localparam int DEPTH = 1 << AWIDTH;
  localparam logic [AWIDTH:0] LEVEL_FULL = (AWIDTH+1)'(DEPTH);
  localparam logic [AWIDTH:0] LEVEL_ROOM = (AWIDTH+1)'(DEPTH - 2);
  localparam logic [10:0] TERM_SOF = 11'h700;
  localparam logic [10:0] TERM_MID = 11'h600;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACTIVE = 2'd1,
    S_DROP   = 2'd2
  } wr_state_t;

  logic [10:0]          mem_q [DEPTH];
  logic [AWIDTH-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AWIDTH:0]      level_q, level_d;
  wr_state_t            state_q, state_d;
  logic [CNT_WIDTH-1:0] ok_q, ok_d, err_q, err_d, ovr_q, ovr_d;

  logic        room_s, pop_s, push_s, wr_req_s;
  logic        inc_ok_s, inc_err_s, inc_ovr_s;
  logic [10:0] wr_entry_s;
  logic [10:0] head_s;

  // Write FSM: classifies each input cycle into data write, terminator write or discard.
  always_comb begin
    state_d    = state_q;
    wr_req_s   = 1'b0;
    wr_entry_s = 11'h000;
    inc_ok_s   = 1'b0;
    inc_err_s  = 1'b0;
    inc_ovr_s  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (rx_valid) begin
          wr_req_s = 1'b1;
          if (rx_error) begin
            wr_entry_s = TERM_SOF;
            inc_err_s  = 1'b1;
            state_d    = S_DROP;
          end else if (room_s) begin
            wr_entry_s = {1'b0, rx_ack, 1'b1, rx_data};
            if (rx_ack) begin
              inc_ok_s = 1'b1;
            end else begin
              state_d = S_ACTIVE;
            end
          end else begin
            wr_entry_s = TERM_SOF;
            inc_err_s  = 1'b1;
            inc_ovr_s  = 1'b1;
            state_d    = S_DROP;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_ACTIVE: begin
        wr_req_s = 1'b1;
        if (rx_error) begin
          wr_entry_s = TERM_MID;
          inc_err_s  = 1'b1;
          state_d    = S_DROP;
        end else if (!rx_valid) begin
          wr_entry_s = TERM_MID;
          inc_err_s  = 1'b1;
          state_d    = S_IDLE;
        end else if (!room_s) begin
          wr_entry_s = TERM_MID;
          inc_err_s  = 1'b1;
          inc_ovr_s  = 1'b1;
          state_d    = S_DROP;
        end else begin
          wr_entry_s = {1'b0, rx_ack, 1'b0, rx_data};
          if (rx_ack) begin
            inc_ok_s = 1'b1;
            state_d  = S_IDLE;
          end else begin
            state_d = S_ACTIVE;
          end
        end
      end
      S_DROP: begin
        if (!rx_valid && !rx_error) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_DROP;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // FIFO bookkeeping; a full FIFO only refuses a write when nothing pops the same cycle.
  always_comb begin
    room_s   = (level_q <= LEVEL_ROOM);
    pop_s    = (level_q != {(AWIDTH+1){1'b0}}) && ll_dst_rdy;
    push_s   = wr_req_s && ((level_q != LEVEL_FULL) || pop_s);
    wr_ptr_d = push_s ? (wr_ptr_q + {{(AWIDTH-1){1'b0}}, 1'b1}) : wr_ptr_q;
    rd_ptr_d = pop_s  ? (rd_ptr_q + {{(AWIDTH-1){1'b0}}, 1'b1}) : rd_ptr_q;
    case ({push_s, pop_s})
      2'b10:   level_d = level_q + {{AWIDTH{1'b0}}, 1'b1};
      2'b01:   level_d = level_q - {{AWIDTH{1'b0}}, 1'b1};
      default: level_d = level_q;
    endcase
    ok_d  = ok_q  + {{(CNT_WIDTH-1){1'b0}}, inc_ok_s};
    err_d = err_q + {{(CNT_WIDTH-1){1'b0}}, inc_err_s};
    ovr_d = ovr_q + {{(CNT_WIDTH-1){1'b0}}, inc_ovr_s};
  end

  // Control state, pointers and counters.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      state_q  <= S_IDLE;
      wr_ptr_q <= {AWIDTH{1'b0}};
      rd_ptr_q <= {AWIDTH{1'b0}};
      level_q  <= {(AWIDTH+1){1'b0}};
      ok_q     <= {CNT_WIDTH{1'b0}};
      err_q    <= {CNT_WIDTH{1'b0}};
      ovr_q    <= {CNT_WIDTH{1'b0}};
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      ok_q     <= ok_d;
      err_q    <= err_d;
      ovr_q    <= ovr_d;
    end
  end

  // Storage array, deliberately without reset.
  always_ff @(posedge clk) begin
    if (push_s && !reset && !clear) begin
      mem_q[wr_ptr_q] <= wr_entry_s;
    end
  end

  assign head_s     = mem_q[rd_ptr_q];
  assign ll_data    = head_s[7:0];
  assign ll_sof     = head_s[8];
  assign ll_eof     = head_s[9];
  assign ll_error   = head_s[10];
  assign ll_src_rdy = (level_q != {(AWIDTH+1){1'b0}});
  assign fifo_level = level_q;
  assign frames_ok  = ok_q;
  assign frames_err = err_q;
  assign overruns   = ovr_q;

endmodule
